// File: rtl/trace_collide_pkg.sv
// Shared constants and FSM encoding for the trail collision checker.
// Grid geometry is fixed: 480 rows by 640 columns on a 799-cell row stride.
package trace_collide_pkg;

    localparam int COORD_W = 10;
    localparam int ADDR_W  = 19;

    localparam logic [ADDR_W-1:0]  GRID_STRIDE = 19'd799;
    localparam logic [COORD_W-1:0] X_MAX       = 10'd479;
    localparam logic [COORD_W-1:0] Y_MAX       = 10'd639;

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        RD2,
        WAIT,
        DONE,
        HALT
    } state_t;

endpackage

// File: rtl/trace_collide_grid_addr.sv
// Maps a head position (row x, column y) to its grid memory address
// and flags positions that fall outside the playfield.
module grid_addr
    import trace_collide_pkg::*;
(
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr,
    output logic               oob
);

    logic [ADDR_W-1:0] x_ext;
    logic [ADDR_W-1:0] y_ext;

    // Widen before multiplying so the row product keeps all 19 bits.
    assign x_ext = {{(ADDR_W-COORD_W){1'b0}}, x};
    assign y_ext = {{(ADDR_W-COORD_W){1'b0}}, y};
    assign addr  = x_ext * GRID_STRIDE + y_ext;
    assign oob   = (x > X_MAX) || (y > Y_MAX);

endmodule

// File: rtl/trace_collide.sv
// Checks both players' next head positions against the trail grid and the
// playfield bounds, then either commits the move or halts with crash flags.
module trace_collide
    import trace_collide_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               move_valid,
    input  logic [COORD_W-1:0] new_x1,
    input  logic [COORD_W-1:0] new_y1,
    input  logic [COORD_W-1:0] new_x2,
    input  logic [COORD_W-1:0] new_y2,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic               rd_data,
    output logic               busy,
    output logic               done,
    output logic               crash1,
    output logic               crash2,
    output logic               commit
);

    state_t state, state_nxt;

    logic [COORD_W-1:0] x1, y1, x2, y2;
    logic [ADDR_W-1:0]  addr1, addr2;
    logic               oob1, oob2;
    logic               hit1;
    logic               any_crash;
    logic               same_cell;
    logic               check1, check2;

    grid_addr u_addr1 (.x(x1), .y(y1), .addr(addr1), .oob(oob1));
    grid_addr u_addr2 (.x(x2), .y(y2), .addr(addr2), .oob(oob2));

    // A head-on meeting kills both players regardless of the grid contents.
    assign same_cell = (x1 == x2) && (y1 == y2);
    assign check1    = oob1 | hit1 | same_cell;
    assign check2    = oob2 | (rd_data & ~oob2) | same_cell;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            x1        <= '0;
            y1        <= '0;
            x2        <= '0;
            y2        <= '0;
            hit1      <= 1'b0;
            any_crash <= 1'b0;
            crash1    <= 1'b0;
            crash2    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && move_valid) begin
                x1 <= new_x1;
                y1 <= new_y1;
                x2 <= new_x2;
                y2 <= new_y2;
            end
            if (state == RD2) begin
                hit1 <= rd_data & ~oob1;
            end
            // Player 2's read returns in WAIT, so the verdict is registered
            // on the way into DONE and is visible alongside the done pulse.
            if (state == WAIT) begin
                crash1    <= crash1 | check1;
                crash2    <= crash2 | check2;
                any_crash <= check1 | check2;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        rd_addr   = '0;
        busy      = 1'b1;
        done      = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (move_valid) state_nxt = RD1;
            end
            RD1: begin
                rd_en     = ~oob1;
                rd_addr   = oob1 ? '0 : addr1;
                state_nxt = RD2;
            end
            RD2: begin
                rd_en     = ~oob2;
                rd_addr   = oob2 ? '0 : addr2;
                state_nxt = WAIT;
            end
            WAIT: state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                commit    = ~any_crash;
                state_nxt = (crash1 | crash2) ? HALT : IDLE;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_trace_collide.sv
// Directed self-checking bench for trace_collide with a one-cycle-latency
// grid memory model driven by the DUT read port.
module tb_trace_collide;

    logic        clock = 1'b0;
    logic        reset;
    logic        move_valid;
    logic [9:0]  new_x1, new_y1, new_x2, new_y2;
    logic        rd_en;
    logic [18:0] rd_addr;
    logic        rd_data = 1'b0;
    logic        busy, done, crash1, crash2, commit;

    int total = 0;
    int bad   = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int rd_before, done_before;

    bit grid_mem [0:524287];

    trace_collide dut (
        .clock(clock), .reset(reset), .move_valid(move_valid),
        .new_x1(new_x1), .new_y1(new_y1), .new_x2(new_x2), .new_y2(new_y2),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .crash1(crash1), .crash2(crash2),
        .commit(commit)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        rd_data <= rd_en ? grid_mem[rd_addr] : 1'b0;
        if (rd_en) rd_cnt <= rd_cnt + 1;
        if (done)  done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Presents a move for one cycle; returns at the negedge of cycle +1.
    task automatic launch(input logic [9:0] ax1, ay1, ax2, ay2);
        new_x1 = ax1; new_y1 = ay1; new_x2 = ax2; new_y2 = ay2;
        move_valid = 1'b1;
        step();
        move_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; move_valid = 1'b0;
        new_x1 = '0; new_y1 = '0; new_x2 = '0; new_y2 = '0;
        step(); step();
        reset = 1'b0;
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_done", done, 0);
        check("rst_commit", commit, 0);
        check("rst_crash1", crash1, 0);
        check("rst_crash2", crash2, 0);
        check("rst_busy", busy, 0);

        // Clean move on an empty grid
        launch(10'd10, 10'd20, 10'd100, 10'd200);
        check("t1_rd1_en", rd_en, 1);
        check("t1_rd1_addr", rd_addr, 8010);
        check("t1_busy", busy, 1);
        step();
        check("t1_rd2_en", rd_en, 1);
        check("t1_rd2_addr", rd_addr, 80100);
        step();
        check("t1_wait_en", rd_en, 0);
        check("t1_wait_addr", rd_addr, 0);
        check("t1_wait_done", done, 0);
        step();
        check("t1_done", done, 1);
        check("t1_commit", commit, 1);
        check("t1_crash1", crash1, 0);
        check("t1_crash2", crash2, 0);
        step();
        check("t1_done_drop", done, 0);
        check("t1_idle_busy", busy, 0);

        // move_valid held high at +1 and +2 must be ignored
        rd_before = rd_cnt; done_before = done_cnt;
        new_x1 = 10'd1; new_y1 = 10'd2; new_x2 = 10'd3; new_y2 = 10'd4;
        move_valid = 1'b1;
        step();
        new_x1 = 10'd50; new_y1 = 10'd50; new_x2 = 10'd60; new_y2 = 10'd60;
        check("t2_rd1_addr", rd_addr, 801);
        step();
        check("t2_rd2_addr", rd_addr, 2401);
        step();
        move_valid = 1'b0;
        step();
        check("t2_done", done, 1);
        check("t2_commit", commit, 1);
        step(); step(); step();
        check("t2_done_count", done_cnt - done_before, 1);
        check("t2_read_count", rd_cnt - rd_before, 2);
        check("t2_idle_busy", busy, 0);

        // Reset while in RD2 aborts the check
        done_before = done_cnt;
        launch(10'd10, 10'd20, 10'd100, 10'd200);
        step();
        reset = 1'b1;
        step();
        check("t5_rd_en", rd_en, 0);
        check("t5_rd_addr", rd_addr, 0);
        check("t5_done", done, 0);
        check("t5_commit", commit, 0);
        check("t5_busy", busy, 0);
        check("t5_crash1", crash1, 0);
        reset = 1'b0;
        launch(10'd5, 10'd6, 10'd7, 10'd8);
        check("t5_abort_no_done", done_cnt - done_before, 0);
        check("t5_new_rd1_addr", rd_addr, 4001);
        step();
        check("t5_new_rd2_addr", rd_addr, 5601);
        step(); step();
        check("t5_new_done", done, 1);
        check("t5_new_commit", commit, 1);
        step();

        // Player 1 runs into an existing trail
        grid_mem[8010] = 1'b1;
        launch(10'd10, 10'd20, 10'd100, 10'd200);
        check("t3_rd1_addr", rd_addr, 8010);
        step(); step(); step();
        check("t3_done", done, 1);
        check("t3_crash1", crash1, 1);
        check("t3_crash2", crash2, 0);
        check("t3_commit", commit, 0);
        step();
        check("t3_halt_busy", busy, 1);
        check("t3_halt_done", done, 0);
        rd_before = rd_cnt; done_before = done_cnt;
        launch(10'd1, 10'd1, 10'd2, 10'd2);
        step(); step(); step(); step();
        check("t3_halt_reads", rd_cnt - rd_before, 0);
        check("t3_halt_dones", done_cnt - done_before, 0);
        check("t3_halt_busy2", busy, 1);
        grid_mem[8010] = 1'b0;
        pulse_reset();
        check("t3_reset_crash1", crash1, 0);
        check("t3_reset_busy", busy, 0);

        // Player 1 leaves the playfield through the bottom edge
        launch(10'd480, 10'd5, 10'd3, 10'd3);
        check("t4_rd1_en", rd_en, 0);
        check("t4_rd1_addr", rd_addr, 0);
        step();
        check("t4_rd2_en", rd_en, 1);
        check("t4_rd2_addr", rd_addr, 2400);
        step(); step();
        check("t4_done", done, 1);
        check("t4_crash1", crash1, 1);
        check("t4_crash2", crash2, 0);
        check("t4_commit", commit, 0);
        step();
        pulse_reset();

        // Head-on collision on an empty grid
        launch(10'd7, 10'd7, 10'd7, 10'd7);
        check("t6_rd1_addr", rd_addr, 5600);
        step(); step(); step();
        check("t6_done", done, 1);
        check("t6_crash1", crash1, 1);
        check("t6_crash2", crash2, 1);
        check("t6_commit", commit, 0);
        step();
        check("t6_halt_busy", busy, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
